// File: rtl/sram_mem_controller_if.sv
// sram_mem_controller_if: pipeline request/response and 16-bit SRAM bus for sram_mem_controller.
interface sram_mem_controller_if #(
  parameter int SRAM_AW = 18
);
  logic               mem_r_en;
  logic               mem_w_en;
  logic [31:0]        addr;
  logic [31:0]        wdata;
  logic [31:0]        rdata;
  logic               ready;
  logic [SRAM_AW-1:0] sram_addr;
  logic [15:0]        sram_dq_out;
  logic [15:0]        sram_dq_in;
  logic               sram_dq_oe;
  logic               sram_we_n;
  modport slave (
    input  mem_r_en, mem_w_en, addr, wdata, sram_dq_in,
    output rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
  modport master (
    output mem_r_en, mem_w_en, addr, wdata, sram_dq_in,
    input  rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
endinterface

// File: rtl/sram_mem_controller.sv
// sram_mem_controller: multi-cycle 32-bit data memory over a 16-bit SRAM, two half-word phases per word.
// Defining SRAM_MEM_CONTROLLER_STATS_EN adds saturating o_rd_count/o_wr_count completion counters.
module sram_mem_controller #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 1,
  parameter int SRAM_AW     = 18
) (
  input logic clk,
  input logic rst,
  sram_mem_controller_if.slave bus
`ifdef SRAM_MEM_CONTROLLER_STATS_EN
  ,
  output logic [15:0] o_rd_count,
  output logic [15:0] o_wr_count
`endif
);
  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;
  state_t             r_state, w_next;
  logic [3:0]         r_cnt;
  logic [SRAM_AW-2:0] r_idx, w_idx_in, w_idx;
  logic [31:0]        r_wdata, w_wdata, r_rdata;
  logic [SRAM_AW-1:0] r_sram_addr;
  logic [15:0]        r_dq_out;
  logic               r_dq_oe, r_we_n;
  logic               w_last, w_start, w_hi, w_wr, w_rd;
  assign w_idx_in = (SRAM_AW-1)'((bus.addr - 32'(BASE_ADDR)) >> 2);
  assign w_last   = r_cnt == 4'(WAIT_CYCLES - 1);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.mem_w_en ? WR_LO : bus.mem_r_en ? RD_LO : IDLE;
      RD_LO:   w_next = w_last ? RD_HI : RD_LO;
      RD_HI:   w_next = w_last ? DONE : RD_HI;
      WR_LO:   w_next = w_last ? WR_HI : WR_LO;
      WR_HI:   w_next = w_last ? DONE : WR_HI;
      default: w_next = IDLE;
    endcase
  end
  // SRAM strobes are registered from the next state so they line up exactly with the phases
  assign w_start = r_state == IDLE && w_next != IDLE;
  assign w_idx   = w_start ? w_idx_in : r_idx;
  assign w_wdata = w_start ? bus.wdata : r_wdata;
  assign w_hi    = w_next == RD_HI || w_next == WR_HI;
  assign w_wr    = w_next == WR_LO || w_next == WR_HI;
  assign w_rd    = w_next == RD_LO || w_next == RD_HI;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rdata     <= '0;
      r_sram_addr <= '0;
      r_dq_out    <= '0;
      r_dq_oe     <= 1'b0;
      r_we_n      <= 1'b1;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state || r_state == IDLE) ? '0 : r_cnt + 4'd1;
      if (w_start) begin
        r_idx   <= w_idx_in;
        r_wdata <= bus.wdata;
      end
      if (w_rd || w_wr) r_sram_addr <= {w_idx, w_hi};
      if (w_wr) r_dq_out <= w_hi ? w_wdata[31:16] : w_wdata[15:0];
      r_dq_oe <= w_wr;
      r_we_n  <= !w_wr;
      if (w_last && r_state == RD_LO) r_rdata[15:0] <= bus.sram_dq_in;
      if (w_last && r_state == RD_HI) r_rdata[31:16] <= bus.sram_dq_in;
    end
  end
`ifdef SRAM_MEM_CONTROLLER_STATS_EN
  logic [15:0] r_rd_count, r_wr_count;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else begin
      if (r_state == RD_HI && w_next == DONE && r_rd_count != 16'hFFFF) r_rd_count <= r_rd_count + 16'd1;
      if (r_state == WR_HI && w_next == DONE && r_wr_count != 16'hFFFF) r_wr_count <= r_wr_count + 16'd1;
    end
  end
  assign o_rd_count = r_rd_count;
  assign o_wr_count = r_wr_count;
`endif
  assign bus.rdata       = r_rdata;
  assign bus.ready       = !(bus.mem_r_en || bus.mem_w_en) || r_state == DONE;
  assign bus.sram_addr   = r_sram_addr;
  assign bus.sram_dq_out = r_dq_out;
  assign bus.sram_dq_oe  = r_dq_oe;
  assign bus.sram_we_n   = r_we_n;
endmodule
